// File: rtl/vec_ctrl_seq_if.sv
// Purpose : instruction handshake + datapath control bundle for vec_ctrl_seq.
// Ports   : slave = sequencer side (takes opcode/valid/zero/mem_ready, drives controls),
//           master = instruction source / datapath side (mirror image).
interface vec_ctrl_seq_if #(
    parameter int VLEN  = 8,
    parameter int LANES = 2
);
    localparam int BEATS = VLEN / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [3:0]    opcode;
    logic          instr_valid;
    logic          instr_ready;
    logic          zero;
    logic          mem_ready;
    logic          mux_pc;
    logic          pc_en;
    logic          sca_reg_w;
    logic          vec_reg_w;
    logic          sca_mux_exe;
    logic          sca_alu_op;
    logic          vec_alu_op;
    logic          w_mem;
    logic          r_mem;
    logic          sca_reg_wd;
    logic          vec_reg_wd;
    logic          vec_reg_wfp;
    logic [BW-1:0] beat_idx;
    logic          busy;
    logic          flag_z;
    logic          illegal;

    modport slave (
        input  opcode, instr_valid, zero, mem_ready,
        output instr_ready, mux_pc, pc_en, sca_reg_w, vec_reg_w, sca_mux_exe,
               sca_alu_op, vec_alu_op, w_mem, r_mem, sca_reg_wd, vec_reg_wd,
               vec_reg_wfp, beat_idx, busy, flag_z, illegal
    );

    modport master (
        output opcode, instr_valid, zero, mem_ready,
        input  instr_ready, mux_pc, pc_en, sca_reg_w, vec_reg_w, sca_mux_exe,
               sca_alu_op, vec_alu_op, w_mem, r_mem, sca_reg_wd, vec_reg_wd,
               vec_reg_wfp, beat_idx, busy, flag_z, illegal
    );
endinterface

// File: rtl/vec_ctrl_seq.sv
// Purpose : scalar/vector instruction sequencer (FETCH -> EXEC or VEC beats -> FETCH).
// Latency : scalar 2 cycles accept-to-ready; ALU vector BEATS+1; memory vector sum(beat waits)+1.
// Backpr. : instr_ready only in FETCH; memory beats stall until mem_ready.
// Ports   : i_clk, i_rst (async, active-low), io_bus (vec_ctrl_seq_if.slave).
module vec_ctrl_seq #(
    parameter int VLEN  = 8,
    parameter int LANES = 2   // VLEN must be a multiple of LANES
) (
    input  logic          i_clk,
    input  logic          i_rst,
    vec_ctrl_seq_if.slave io_bus
);
    localparam int BEATS = VLEN / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    localparam logic [3:0] OP_SUM   = 4'b0000;
    localparam logic [3:0] OP_SUMV  = 4'b0001;
    localparam logic [3:0] OP_SUMI  = 4'b0010;
    localparam logic [3:0] OP_MULFV = 4'b0011;
    localparam logic [3:0] OP_LDV   = 4'b0100;
    localparam logic [3:0] OP_STV   = 4'b0101;
    localparam logic [3:0] OP_CMP   = 4'b0110;
    localparam logic [3:0] OP_NOP   = 4'b0111;
    localparam logic [3:0] OP_JEQ   = 4'b1001;

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_VEC} state_t;

    state_t        r_state, w_state_nxt;
    logic [3:0]    r_op;
    logic [BW-1:0] r_beat, w_beat_nxt;
    logic          r_flag_z;

    logic w_accept, w_in_vec, w_mem_op, w_beat_done, w_last;
    logic w_mux_pc, w_pc_en, w_sca_reg_w, w_vec_reg_w, w_sca_mux_exe, w_sca_alu_op;
    logic w_vec_alu_op, w_w_mem, w_r_mem, w_vec_reg_wd, w_vec_reg_wfp, w_illegal;

    assign w_accept = io_bus.instr_valid && (r_state == S_FETCH);
    assign w_in_vec = (io_bus.opcode == OP_SUMV) || (io_bus.opcode == OP_MULFV) ||
                      (io_bus.opcode == OP_LDV)  || (io_bus.opcode == OP_STV);
    // ALU beats always complete; memory beats complete only on mem_ready.
    assign w_mem_op    = (r_op == OP_LDV) || (r_op == OP_STV);
    assign w_beat_done = !w_mem_op || io_bus.mem_ready;
    assign w_last      = (r_beat == LAST_BEAT);

    always_comb begin
        w_state_nxt   = r_state;
        w_beat_nxt    = r_beat;
        w_mux_pc      = 1'b0;
        w_pc_en       = 1'b0;
        w_sca_reg_w   = 1'b0;
        w_vec_reg_w   = 1'b0;
        w_sca_mux_exe = 1'b0;
        w_sca_alu_op  = 1'b0;
        w_vec_alu_op  = 1'b0;
        w_w_mem       = 1'b0;
        w_r_mem       = 1'b0;
        w_vec_reg_wd  = 1'b0;
        w_vec_reg_wfp = 1'b0;
        w_illegal     = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (w_accept) begin
                    w_state_nxt = w_in_vec ? S_VEC : S_EXEC;
                    w_beat_nxt  = '0;
                end
            end
            S_EXEC: begin
                w_pc_en     = 1'b1;
                w_state_nxt = S_FETCH;
                case (r_op)
                    OP_SUM:  w_sca_reg_w = 1'b1;
                    OP_SUMI: begin
                        w_sca_reg_w   = 1'b1;
                        w_sca_mux_exe = 1'b1;
                    end
                    OP_CMP:  w_sca_alu_op = 1'b1;
                    OP_NOP:  ;
                    // Branch decision uses the flag captured by the last CMP, never the live zero.
                    OP_JEQ:  w_mux_pc = r_flag_z;
                    default: w_illegal = 1'b1;
                endcase
            end
            S_VEC: begin
                case (r_op)
                    OP_SUMV:  w_vec_reg_w = 1'b1;
                    OP_MULFV: begin
                        w_vec_reg_w   = 1'b1;
                        w_vec_alu_op  = 1'b1;
                        w_vec_reg_wfp = 1'b1;
                    end
                    OP_LDV: begin
                        w_r_mem      = 1'b1;
                        w_vec_reg_wd = 1'b1;
                        w_vec_reg_w  = io_bus.mem_ready;
                    end
                    OP_STV:   w_w_mem = 1'b1;
                    default:  ;
                endcase
                if (w_beat_done) begin
                    if (w_last) begin
                        w_pc_en     = 1'b1;
                        w_beat_nxt  = '0;
                        w_state_nxt = S_FETCH;
                    end else begin
                        w_beat_nxt = r_beat + 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state  <= S_FETCH;
            r_op     <= OP_NOP;
            r_beat   <= '0;
            r_flag_z <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
            if (w_accept) r_op <= io_bus.opcode;
            if ((r_state == S_EXEC) && (r_op == OP_CMP)) r_flag_z <= io_bus.zero;
        end
    end

    assign io_bus.instr_ready = (r_state == S_FETCH);
    assign io_bus.busy        = (r_state != S_FETCH);
    assign io_bus.beat_idx    = r_beat;
    assign io_bus.flag_z      = r_flag_z;
    assign io_bus.mux_pc      = w_mux_pc;
    assign io_bus.pc_en       = w_pc_en;
    assign io_bus.sca_reg_w   = w_sca_reg_w;
    assign io_bus.vec_reg_w   = w_vec_reg_w;
    assign io_bus.sca_mux_exe = w_sca_mux_exe;
    assign io_bus.sca_alu_op  = w_sca_alu_op;
    assign io_bus.vec_alu_op  = w_vec_alu_op;
    assign io_bus.w_mem       = w_w_mem;
    assign io_bus.r_mem       = w_r_mem;
    // No instruction in this ISA writes memory data into the scalar file.
    assign io_bus.sca_reg_wd  = 1'b0;
    assign io_bus.vec_reg_wd  = w_vec_reg_wd;
    assign io_bus.vec_reg_wfp = w_vec_reg_wfp;
    assign io_bus.illegal     = w_illegal;
endmodule

// File: tb/tb_vec_ctrl_seq.sv
// Purpose : directed check of vec_ctrl_seq (VLEN=8, LANES=2 -> 4 beats).
// Latency : n/a (bench).
// Backpr. : drives mem_ready stalls and instr_valid while busy.
module tb_vec_ctrl_seq;
    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    vec_ctrl_seq_if #(.VLEN(8), .LANES(2)) bus ();

    vec_ctrl_seq #(.VLEN(8), .LANES(2)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Control bit positions in the packed compare word.
    localparam logic [12:0] MUX  = 13'h1000;
    localparam logic [12:0] PC   = 13'h0800;
    localparam logic [12:0] SRW  = 13'h0400;
    localparam logic [12:0] VRW  = 13'h0200;
    localparam logic [12:0] SMX  = 13'h0100;
    localparam logic [12:0] SALU = 13'h0080;
    localparam logic [12:0] VALU = 13'h0040;
    localparam logic [12:0] WMEM = 13'h0020;
    localparam logic [12:0] RMEM = 13'h0010;
    localparam logic [12:0] SWD  = 13'h0008;
    localparam logic [12:0] VWD  = 13'h0004;
    localparam logic [12:0] WFP  = 13'h0002;
    localparam logic [12:0] ILL  = 13'h0001;

    function automatic logic [12:0] ctrl_now();
        return {bus.mux_pc, bus.pc_en, bus.sca_reg_w, bus.vec_reg_w, bus.sca_mux_exe,
                bus.sca_alu_op, bus.vec_alu_op, bus.w_mem, bus.r_mem, bus.sca_reg_wd,
                bus.vec_reg_wd, bus.vec_reg_wfp, bus.illegal};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic        zero;
        logic [12:0] exp_ctrl;
        logic        exp_flag;
    } scal_vec_t;

    scal_vec_t tbl [10];
    int busy_cnt;

    initial begin
        tbl[0] = '{"SUM",     4'b0000, 1'b0, PC | SRW,       1'b0};
        tbl[1] = '{"SUMI",    4'b0010, 1'b0, PC | SRW | SMX, 1'b0};
        tbl[2] = '{"NOP",     4'b0111, 1'b1, PC,             1'b0};
        tbl[3] = '{"CMP_z1",  4'b0110, 1'b1, PC | SALU,      1'b1};
        tbl[4] = '{"JEQ_t",   4'b1001, 1'b0, PC | MUX,       1'b1};
        tbl[5] = '{"CMP_z0",  4'b0110, 1'b0, PC | SALU,      1'b0};
        tbl[6] = '{"JEQ_nt",  4'b1001, 1'b1, PC,             1'b0};
        tbl[7] = '{"ILL_F",   4'b1111, 1'b0, PC | ILL,       1'b0};
        tbl[8] = '{"ILL_8",   4'b1000, 1'b1, PC | ILL,       1'b0};
        tbl[9] = '{"CMP_z1b", 4'b0110, 1'b1, PC | SALU,      1'b1};

        rst = 1'b0;
        bus.opcode = 4'b0000;
        bus.instr_valid = 1'b0;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b0;

        // Reset state
        @(negedge clk); #1;
        chk("rst_ready", 32'(bus.instr_ready), 32'd1);
        chk("rst_busy",  32'(bus.busy),        32'd0);
        chk("rst_ctrl",  32'(ctrl_now()),      32'd0);
        chk("rst_beat",  32'(bus.beat_idx),    32'd0);
        chk("rst_flag",  32'(bus.flag_z),      32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Scalar table: accept cycle, single EXEC cycle, back to FETCH.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.instr_valid = 1'b1;
            bus.opcode = tbl[i].op;
            bus.zero = tbl[i].zero;
            #1;
            chk({tbl[i].name, "_fetch_ctrl"}, 32'(ctrl_now()), 32'd0);
            chk({tbl[i].name, "_fetch_rdy"},  32'(bus.instr_ready), 32'd1);
            @(negedge clk);
            bus.instr_valid = 1'b0;
            bus.opcode = 4'b0101;   // scrambled: the latched opcode must be used
            #1;
            chk({tbl[i].name, "_exec_ctrl"}, 32'(ctrl_now()), 32'(tbl[i].exp_ctrl));
            chk({tbl[i].name, "_exec_busy"}, 32'(bus.busy), 32'd1);
            chk({tbl[i].name, "_exec_rdy"},  32'(bus.instr_ready), 32'd0);
            @(negedge clk); #1;
            chk({tbl[i].name, "_done_rdy"},  32'(bus.instr_ready), 32'd1);
            chk({tbl[i].name, "_done_ctrl"}, 32'(ctrl_now()), 32'd0);
            chk({tbl[i].name, "_flag"},      32'(bus.flag_z), 32'(tbl[i].exp_flag));
        end

        // MULFV: 4 back-to-back beats, mem_ready low (ignored), SUM offered while busy.
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.opcode = 4'b0011;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        bus.opcode = 4'b0000;
        for (int b = 0; b < 4; b++) begin
            if (b > 0) @(negedge clk);
            if (b == 3) bus.instr_valid = 1'b0;
            #1;
            chk("mulfv_beat", 32'(bus.beat_idx), 32'(b));
            chk("mulfv_ctrl", 32'(ctrl_now()), 32'(VRW | VALU | WFP | ((b == 3) ? PC : 13'h0)));
        end
        @(negedge clk); #1;
        chk("mulfv_end_rdy",  32'(bus.instr_ready), 32'd1);
        chk("mulfv_end_beat", 32'(bus.beat_idx), 32'd0);
        chk("mulfv_end_ctrl", 32'(ctrl_now()), 32'd0);

        // LDV: two stall cycles then ready on every beat -> 12 busy cycles.
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.opcode = 4'b0100;
        busy_cnt = 0;
        for (int b = 0; b < 4; b++) begin
            for (int w = 0; w < 3; w++) begin
                @(negedge clk);
                bus.instr_valid = 1'b0;
                bus.mem_ready = (w == 2);
                #1;
                if (bus.busy) busy_cnt++;
                chk("ldv_beat", 32'(bus.beat_idx), 32'(b));
                chk("ldv_ctrl", 32'(ctrl_now()),
                    32'(RMEM | VWD | ((w == 2) ? VRW : 13'h0) | ((w == 2 && b == 3) ? PC : 13'h0)));
            end
        end
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        if (bus.busy) busy_cnt++;
        chk("ldv_busy_cycles", 32'(busy_cnt), 32'd12);
        chk("ldv_end_rdy", 32'(bus.instr_ready), 32'd1);

        // STV: one stall per beat, w_mem held.
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.opcode = 4'b0101;
        for (int b = 0; b < 4; b++) begin
            for (int w = 0; w < 2; w++) begin
                @(negedge clk);
                bus.instr_valid = 1'b0;
                bus.mem_ready = (w == 1);
                #1;
                chk("stv_beat", 32'(bus.beat_idx), 32'(b));
                chk("stv_ctrl", 32'(ctrl_now()), 32'(WMEM | ((w == 1 && b == 3) ? PC : 13'h0)));
            end
        end
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        chk("stv_end_rdy", 32'(bus.instr_ready), 32'd1);

        // Reset during beat 2 of SUMV (flag_z is 1 from the last CMP row).
        chk("pre_rst_flag", 32'(bus.flag_z), 32'd1);
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.opcode = 4'b0001;
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            bus.instr_valid = 1'b0;
            #1;
            chk("sumv_beat", 32'(bus.beat_idx), 32'(b));
            chk("sumv_ctrl", 32'(ctrl_now()), 32'(VRW));
        end
        rst = 1'b0;
        #1;
        chk("abort_ctrl", 32'(ctrl_now()), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_rdy",  32'(bus.instr_ready), 32'd1);
        chk("abort_beat", 32'(bus.beat_idx), 32'd0);
        chk("abort_flag", 32'(bus.flag_z), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.opcode = 4'b0001;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        #1;
        chk("restart_beat", 32'(bus.beat_idx), 32'd0);
        chk("restart_ctrl", 32'(ctrl_now()), 32'(VRW));
        for (int b = 1; b < 4; b++) @(negedge clk);
        #1;
        chk("restart_last", 32'(ctrl_now()), 32'(VRW | PC));
        @(negedge clk); #1;
        chk("restart_rdy", 32'(bus.instr_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vec_ctrl_seq.md
VEC_CTRL_SEQ -- requirements
Module: vec_ctrl_seq

Interface
REQ-001 Parameter VLEN, default 8: vector elements per instruction.
REQ-002 Parameter LANES, default 2: elements per beat; VLEN SHALL be a multiple of LANES; BEATS = VLEN/LANES; BW = max(1, clog2(BEATS)).
REQ-003 clk  in  1  single clock, rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 opcode  in  4  instruction opcode; sampled on accept.
REQ-006 instr_valid  in  1  opcode valid.
REQ-007 instr_ready  out  1  sequencer can accept an instruction.
REQ-008 zero  in  1  scalar ALU zero result.
REQ-009 mem_ready  in  1  data memory completes the current access.
REQ-010 mux_pc, pc_en, sca_reg_w, vec_reg_w, sca_mux_exe, sca_alu_op, vec_alu_op, w_mem, r_mem, sca_reg_wd, vec_reg_wd, vec_reg_wfp  out  1 each  datapath controls.
REQ-011 beat_idx  out  BW  current vector beat; element base = beat_idx*LANES.
REQ-012 busy  out  1  high in EXEC or VEC.
REQ-013 flag_z  out  1  registered compare flag.
REQ-014 illegal  out  1  one-cycle pulse for an undefined opcode.

Function
REQ-015 The FSM SHALL have three states: FETCH, EXEC (scalar, 1 cycle) and VEC (BEATS beats).
REQ-016 instr_ready SHALL equal (state==FETCH); accept = instr_valid & instr_ready; the opcode SHALL be latched on accept.
REQ-017 On accept, scalar opcodes SHALL go to EXEC and vector opcodes (0001, 0011, 0100, 0101) SHALL go to VEC with beat_idx=0.
REQ-018 In FETCH, all datapath controls SHALL be 0.
REQ-019 EXEC SHALL last exactly one cycle, assert pc_en=1, and return to FETCH.
REQ-020 SUM 0000: sca_reg_w=1, sca_mux_exe=0, sca_alu_op=0.
REQ-021 SUMI 0010: sca_reg_w=1, sca_mux_exe=1, sca_alu_op=0.
REQ-022 CMP 0110: sca_alu_op=1, no register write; flag_z SHALL load zero at the end of the EXEC cycle and hold until the next CMP or reset.
REQ-023 NOP 0111: no controls except pc_en.
REQ-024 JEQ 1001: mux_pc = flag_z, using the registered flag only (the live zero input SHALL be ignored).
REQ-025 Any other scalar opcode SHALL behave as NOP and pulse illegal=1 in its EXEC cycle.
REQ-026 SUMV 0001: each beat asserts vec_reg_w=1 and vec_alu_op=0.
REQ-027 MULFV 0011: each beat asserts vec_reg_w=1, vec_alu_op=1 and vec_reg_wfp=1.
REQ-028 LDV 0100: r_mem=1 and vec_reg_wd=1 are held each beat until mem_ready; vec_reg_w=1 only in the cycle where mem_ready=1.
REQ-029 STV 0101: w_mem=1 is held each beat until mem_ready.
REQ-030 A beat SHALL advance on every cycle for ALU vector ops, and only on mem_ready=1 for LDV/STV; mem_ready SHALL be ignored outside memory beats.
REQ-031 On completion of beat BEATS-1, pc_en=1 for that cycle only, beat_idx SHALL wrap to 0, and the FSM SHALL return to FETCH.
REQ-032 Latency: a scalar op takes 2 cycles from accept to next instr_ready; an ALU vector op takes BEATS+1; a memory op takes sum(beat waits)+1.
REQ-033 pc_en SHALL be asserted exactly once per accepted instruction.
REQ-034 instr_valid while busy SHALL be ignored, with no latch of the new opcode.

Reset
REQ-035 While rst=0: state=FETCH, beat_idx=0, flag_z=0, all datapath controls=0, illegal=0, busy=0, instr_ready=1.
REQ-036 Reset asserted mid-VEC or mid-EXEC SHALL abort immediately with no pc_en and no further writes.

Verification
REQ-037 SUM, SUMI, NOP: each gives exactly one EXEC cycle with the stated controls and pc_en=1; instr_ready is back to 1 two cycles after accept.
REQ-038 CMP with zero=1, then JEQ -> mux_pc=1; CMP with zero=0, then JEQ with zero=1 driven during the JEQ -> mux_pc=0.
REQ-039 MULFV with VLEN=8, LANES=2 -> 4 consecutive beats, beat_idx 0,1,2,3, vec_reg_wfp=1 in all of them, pc_en only in beat 3.
REQ-040 LDV with mem_ready low for 2 cycles per beat -> r_mem held, vec_reg_w only on the ready cycles, 12 busy cycles in total.
REQ-041 rst pulsed low during beat 2 of SUMV -> all outputs 0 at once and flag_z=0; the next accepted instruction starts at beat_idx=0.
REQ-042 Opcode 1111 -> illegal=1 for one cycle, pc_en=1, no writes; instr_valid asserted while busy -> no accept.
